// File: rtl/vga_sync_decoder_pkg.sv
// Shared timing constants, lock FSM encoding and helpers for the VGA sync decoder.
// Constants describe the nominal 640x480 frame also produced by the sync generators.
package vga_sync_decoder_pkg;

  localparam int DW_DEF           = 10;
  localparam int H_TOTAL_DEF      = 800;
  localparam int H_ACTIVE_DEF     = 640;
  localparam int H_SYNC_START_DEF = 657;
  localparam int H_SYNC_W_DEF     = 95;
  localparam int V_TOTAL_DEF      = 525;
  localparam int V_ACTIVE_DEF     = 480;
  localparam int V_SYNC_START_DEF = 490;
  localparam int LOCK_LINES_DEF   = 4;

  typedef enum logic [1:0] {
    ST_SEARCH  = 2'd0,
    ST_MEASURE = 2'd1,
    ST_LOCKED  = 2'd2
  } state_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/vga_sync_decoder_edge.sv
// Per-tick sync input register with falling-edge flag and active-low pulse width
// measurement; the width of the last completed low pulse is held until the next rise.
module vga_sync_decoder_edge #(
  parameter int CW = 11
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          enable,
  input  logic          i_sync,
  output logic          o_fall,
  output logic [CW-1:0] o_low_width
);

  logic          r_prev;
  logic [CW-1:0] r_low_cnt;
  logic [CW-1:0] r_low_width;
  logic          w_rise;

  assign o_fall      = enable & r_prev & ~i_sync;
  assign w_rise      = enable & ~r_prev & i_sync;
  assign o_low_width = r_low_width;

  // The fall tick itself counts as the first low tick of the pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_prev      <= 1'b1;
      r_low_cnt   <= '0;
      r_low_width <= '0;
    end else if (enable) begin
      r_prev <= i_sync;
      if (o_fall) begin
        r_low_cnt <= CW'(1);
      end else if (w_rise) begin
        r_low_width <= r_low_cnt;
        r_low_cnt   <= '0;
      end else if (!i_sync && (r_low_cnt != '1)) begin
        r_low_cnt <= r_low_cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/vga_sync_decoder.sv
// Recovers pixel coordinates, active video and line/frame strobes from an external
// VGA sync stream, and tracks horizontal lock against the nominal line timing.
module vga_sync_decoder
  import vga_sync_decoder_pkg::*;
#(
  parameter int DW           = DW_DEF,
  parameter int H_TOTAL      = H_TOTAL_DEF,
  parameter int H_ACTIVE     = H_ACTIVE_DEF,
  parameter int H_SYNC_START = H_SYNC_START_DEF,
  parameter int H_SYNC_W     = H_SYNC_W_DEF,
  parameter int V_TOTAL      = V_TOTAL_DEF,
  parameter int V_ACTIVE     = V_ACTIVE_DEF,
  parameter int V_SYNC_START = V_SYNC_START_DEF,
  parameter int LOCK_LINES   = LOCK_LINES_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          enable,
  input  logic          h_synch,
  input  logic          v_synch,
  output logic [DW-1:0] h_pos,
  output logic [DW-1:0] v_pos,
  output logic          active_video,
  output logic          line_start,
  output logic          frame_start,
  output logic          h_locked,
  output logic          locked,
  output logic [7:0]    err_count
);

  localparam int PW = DW + 1;
  localparam logic [DW-1:0] LP_H_LAST       = DW'(H_TOTAL - 1);
  localparam logic [DW-1:0] LP_H_ACTIVE     = DW'(H_ACTIVE);
  localparam logic [DW-1:0] LP_H_SYNC_START = DW'(H_SYNC_START);
  localparam logic [DW-1:0] LP_V_LAST       = DW'(V_TOTAL - 1);
  localparam logic [DW-1:0] LP_V_ACTIVE     = DW'(V_ACTIVE);
  localparam logic [DW-1:0] LP_V_SYNC_START = DW'(V_SYNC_START);
  localparam logic [PW-1:0] LP_PER_NOM      = PW'(H_TOTAL);
  localparam logic [PW-1:0] LP_PER_TO       = PW'(2 * H_TOTAL);
  localparam logic [PW-1:0] LP_SYNC_W       = PW'(H_SYNC_W);
  localparam logic [7:0]    LP_GOOD_LAST    = 8'(LOCK_LINES - 1);

  logic          w_h_fall;
  logic          w_v_fall;
  logic [PW-1:0] w_h_low_width;
  logic [PW-1:0] w_unused_v_width;
  logic          w_h_wrap;
  logic          w_line_good;
  logic          w_timeout;

  logic [DW-1:0] r_h_pos;
  logic [DW-1:0] r_v_pos;
  logic          r_v_pend;
  logic [PW-1:0] r_per;
  logic          r_line_start;
  logic          r_frame_start;
  state_t        r_state;
  logic [7:0]    r_good_cnt;
  logic          r_h_locked;
  logic          r_locked;
  logic [7:0]    r_err_count;

  vga_sync_decoder_edge #(.CW(PW)) u_h_edge (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .i_sync      (h_synch),
    .o_fall      (w_h_fall),
    .o_low_width (w_h_low_width)
  );

  vga_sync_decoder_edge #(.CW(PW)) u_v_edge (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .i_sync      (v_synch),
    .o_fall      (w_v_fall),
    .o_low_width (w_unused_v_width)
  );

  assign w_h_wrap    = !w_h_fall && (r_h_pos == LP_H_LAST);
  assign w_line_good = (r_per == LP_PER_NOM) && (w_h_low_width == LP_SYNC_W);
  assign w_timeout   = !w_h_fall && (r_per >= LP_PER_TO);

  // Position counters free-run; an h fall re-anchors them to the sync position.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_h_pos       <= '0;
      r_v_pos       <= '0;
      r_v_pend      <= 1'b0;
      r_per         <= '0;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
      if (enable) begin
        if (w_h_fall) begin
          r_h_pos <= LP_H_SYNC_START;
        end else if (w_h_wrap) begin
          r_h_pos      <= '0;
          r_line_start <= 1'b1;
        end else begin
          r_h_pos <= r_h_pos + DW'(1);
        end

        if (w_h_fall && (w_v_fall || r_v_pend)) begin
          r_v_pos  <= LP_V_SYNC_START;
          r_v_pend <= 1'b0;
        end else begin
          if (w_v_fall) r_v_pend <= 1'b1;
          if (w_h_wrap) begin
            if (r_v_pos == LP_V_LAST) begin
              r_v_pos       <= '0;
              r_frame_start <= 1'b1;
            end else begin
              r_v_pos <= r_v_pos + DW'(1);
            end
          end
        end

        if (w_h_fall)            r_per <= PW'(1);
        else if (r_per != '1)    r_per <= r_per + PW'(1);
      end
    end
  end

  // Lock FSM; the clear in the case statement overrides a same-tick v fall set.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_SEARCH;
      r_good_cnt  <= '0;
      r_h_locked  <= 1'b0;
      r_locked    <= 1'b0;
      r_err_count <= '0;
    end else if (enable) begin
      if (w_v_fall && r_h_locked) r_locked <= 1'b1;
      case (r_state)
        ST_SEARCH: begin
          if (w_h_fall) begin
            r_state    <= ST_MEASURE;
            r_good_cnt <= '0;
          end
        end
        ST_MEASURE: begin
          if (w_h_fall) begin
            if (!w_line_good) begin
              r_good_cnt <= '0;
            end else if (r_good_cnt == LP_GOOD_LAST) begin
              r_state    <= ST_LOCKED;
              r_h_locked <= 1'b1;
              r_good_cnt <= '0;
            end else begin
              r_good_cnt <= r_good_cnt + 8'd1;
            end
          end else if (w_timeout) begin
            r_state <= ST_SEARCH;
          end
        end
        ST_LOCKED: begin
          if ((w_h_fall && !w_line_good) || w_timeout) begin
            r_state     <= ST_SEARCH;
            r_h_locked  <= 1'b0;
            r_locked    <= 1'b0;
            r_err_count <= sat_inc8(r_err_count);
          end
        end
        default: r_state <= ST_SEARCH;
      endcase
    end
  end

  assign h_pos        = r_h_pos;
  assign v_pos        = r_v_pos;
  assign line_start   = r_line_start;
  assign frame_start  = r_frame_start;
  assign h_locked     = r_h_locked;
  assign locked       = r_locked;
  assign err_count    = r_err_count;
  assign active_video = r_locked && (r_h_pos < LP_H_ACTIVE) && (r_v_pos < LP_V_ACTIVE);

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Directed bench for vga_sync_decoder: a nominal 640x480 sync stream model drives the
// decoder, with planted timing faults, sync stalls, enable gaps and a mid-line reset.
module tb_vga_sync_decoder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b0;
  logic       h_synch = 1'b1;
  logic       v_synch = 1'b1;
  logic [9:0] h_pos;
  logic [9:0] v_pos;
  logic       active_video;
  logic       line_start;
  logic       frame_start;
  logic       h_locked;
  logic       locked;
  logic [7:0] err_count;

  vga_sync_decoder dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .h_synch      (h_synch),
    .v_synch      (v_synch),
    .h_pos        (h_pos),
    .v_pos        (v_pos),
    .active_video (active_video),
    .line_start   (line_start),
    .frame_start  (frame_start),
    .h_locked     (h_locked),
    .locked       (locked),
    .err_count    (err_count)
  );

  // clock / reset
  always #5 clk = ~clk;

  // stream model state: gh/gv is the pixel driven on the next tick
  int gh = 0;
  int gv = 484;
  int line_len = 800;
  int hs_w = 95;
  int force_mode = 0;   // 0 normal, 1 h held high, 2 h held low
  bit use_div4 = 1'b0;
  int act_acc = 0;
  int last_act = -1;
  int fs_cnt = 0;
  int n_checks = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic drive_inputs();
    if (force_mode == 1)      h_synch = 1'b1;
    else if (force_mode == 2) h_synch = 1'b0;
    else                      h_synch = !((gh >= 656) && (gh < 656 + hs_w));
    v_synch = !((gv == 490) || (gv == 491));
  endtask

  // driver: one enable tick of the stream
  task automatic tick();
    drive_inputs();
    if (use_div4) begin
      enable = 1'b0;
      repeat (3) @(posedge clk);
      #1;
    end
    enable = 1'b1;
    act_acc += int'(active_video);
    @(posedge clk);
    #1;
    fs_cnt += int'(frame_start);
    gh++;
    if (gh >= line_len) begin
      gh = 0;
      gv = (gv == 524) ? 0 : gv + 1;
      last_act = act_acc;
      act_acc = 0;
    end
  endtask

  task automatic run_to(input int h, input int v);
    int i;
    i = 0;
    while (!(gh == h && gv == v) && i < 40000) begin
      tick();
      i++;
    end
    if (!(gh == h && gv == v)) begin
      n_checks++;
      $error("FAIL run_to: tick budget expired at h=%0d v=%0d", gh, gv);
    end
  endtask

  task automatic run_to_h(input int h);
    run_to(h, (gh < h) ? gv : ((gv == 524) ? 0 : gv + 1));
  endtask

  task automatic next_fall();
    run_to_h(656);
    tick();
  endtask

  initial begin
    // reset with toggling inputs
    rst = 1'b1;
    repeat (5) begin
      h_synch = 1'($urandom_range(0, 1));
      v_synch = 1'($urandom_range(0, 1));
      enable  = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
    end
    chk("rst_h_pos", 32'(h_pos), 0);
    chk("rst_v_pos", 32'(v_pos), 0);
    chk("rst_active", 32'(active_video), 0);
    chk("rst_line_start", 32'(line_start), 0);
    chk("rst_frame_start", 32'(frame_start), 0);
    chk("rst_h_locked", 32'(h_locked), 0);
    chk("rst_locked", 32'(locked), 0);
    chk("rst_err_count", 32'(err_count), 0);
    rst = 1'b0;

    // acquisition: first line with enable every 4th clock
    use_div4 = 1'b1;
    run_to(656, 484);
    tick();
    chk("fall1_h_pos", 32'(h_pos), 657);
    chk("fall1_h_locked", 32'(h_locked), 0);
    use_div4 = 1'b0;
    run_to(656, 487);
    tick();
    chk("fall4_h_locked", 32'(h_locked), 0);
    run_to(656, 488);
    tick();
    chk("fall5_h_locked", 32'(h_locked), 1);
    chk("fall5_locked", 32'(locked), 0);
    chk("fall5_h_pos", 32'(h_pos), 657);
    run_to(0, 490);
    tick();
    chk("vfall_locked", 32'(locked), 1);
    run_to(656, 490);
    tick();
    chk("vload_v_pos", 32'(v_pos), 490);
    chk("vload_h_pos", 32'(h_pos), 657);

    // frame wrap and active video accounting
    fs_cnt = 0;
    run_to(0, 524);
    chk("act_line523", 32'(last_act), 0);
    run_to(799, 524);
    tick();
    chk("wrap_frame_start", 32'(frame_start), 1);
    chk("wrap_line_start", 32'(line_start), 1);
    chk("wrap_v_pos", 32'(v_pos), 0);
    chk("wrap_h_pos", 32'(h_pos), 0);
    run_to(0, 1);
    chk("act_line0", 32'(last_act), 640);
    chk("frame_start_count", 32'(fs_cnt), 1);
    chk("line1_v_pos", 32'(v_pos), 1);

    // one short line (799 ticks)
    line_len = 799;
    run_to(0, 2);
    line_len = 800;
    run_to(656, 2);
    chk("pre_bad_h_locked", 32'(h_locked), 1);
    tick();
    chk("short_h_locked", 32'(h_locked), 0);
    chk("short_locked", 32'(locked), 0);
    chk("short_err_count", 32'(err_count), 1);
    repeat (4) next_fall();
    chk("relock1_early", 32'(h_locked), 0);
    next_fall();
    chk("relock1_h_locked", 32'(h_locked), 1);
    chk("relock1_locked", 32'(locked), 0);

    // one narrow sync pulse (94 ticks)
    hs_w = 94;
    repeat (200) tick();
    hs_w = 95;
    next_fall();
    chk("narrow_h_locked", 32'(h_locked), 0);
    chk("narrow_err_count", 32'(err_count), 2);
    repeat (5) next_fall();
    chk("relock2_h_locked", 32'(h_locked), 1);

    // h_synch stuck high
    force_mode = 1;
    repeat (1599) tick();
    chk("hi_1599_h_locked", 32'(h_locked), 1);
    tick();
    chk("hi_1600_h_locked", 32'(h_locked), 0);
    chk("hi_err_count", 32'(err_count), 3);
    run_to_h(0);
    force_mode = 0;
    repeat (5) next_fall();
    chk("relock3_h_locked", 32'(h_locked), 1);

    // h_synch stuck low
    force_mode = 2;
    repeat (1599) tick();
    chk("lo_1599_h_locked", 32'(h_locked), 1);
    tick();
    chk("lo_1600_h_locked", 32'(h_locked), 0);
    chk("lo_err_count", 32'(err_count), 4);
    run_to_h(0);
    force_mode = 0;
    repeat (5) next_fall();
    chk("relock4_h_locked", 32'(h_locked), 1);

    // enable held low mid-line with noisy syncs
    run_to_h(400);
    repeat (50) begin
      enable  = 1'b0;
      h_synch = 1'($urandom_range(0, 1));
      v_synch = 1'($urandom_range(0, 1));
      @(posedge clk);
    end
    #1;
    chk("stall_h_pos", 32'(h_pos), 400);
    chk("stall_h_locked", 32'(h_locked), 1);
    chk("stall_err_count", 32'(err_count), 4);
    next_fall();
    chk("post_stall_h_locked", 32'(h_locked), 1);
    chk("post_stall_h_pos", 32'(h_pos), 657);

    // synchronous reset mid-line
    run_to_h(300);
    drive_inputs();
    enable = 1'b1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_rst_h_pos", 32'(h_pos), 0);
    chk("mid_rst_v_pos", 32'(v_pos), 0);
    chk("mid_rst_h_locked", 32'(h_locked), 0);
    chk("mid_rst_err_count", 32'(err_count), 0);
    chk("mid_rst_active", 32'(active_video), 0);
    rst = 1'b0;
    enable = 1'b0;

    // report
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
